// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

    localparam int N_DEFAULT = 4;
    localparam int K_DEFAULT = 4;

    localparam logic [7:0] FP8_ZERO = 8'h00;
    localparam int         BF16_W   = 16;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        FEED    = 3'd2,
        CAPTURE = 3'd3,
        OUT     = 3'd4
    } state_e;

endpackage

// File: rtl/systolic_skew_gen.sv
// Skewed wavefront generator: picks the A/B operand bytes for feed step t
// and registers them onto the array row and column edges.
// One index calculation (k = t - lane) serves both edges.
module systolic_skew_gen
    import systolic_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int K  = K_DEFAULT,
    parameter int TW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wave_en,
    input  logic [TW-1:0]    t,
    input  logic [8*N*K-1:0] a_buf,
    input  logic [8*N*K-1:0] b_buf,
    output logic [8*N-1:0]   arr_a,
    output logic [8*N-1:0]   arr_b
);

    logic [8*N-1:0] a_wave;
    logic [8*N-1:0] b_wave;
    int             k;

    // Lane e carries reduction index k = t - e; outside 0..K-1 the lane idles at zero.
    always_comb begin
        a_wave = {N{FP8_ZERO}};
        b_wave = {N{FP8_ZERO}};
        k      = 0;
        for (int e = 0; e < N; e++) begin
            k = int'(t) - e;
            if (wave_en && k >= 0 && k < K) begin
                a_wave[8*e +: 8] = a_buf[8*(e*K + k) +: 8];
                b_wave[8*e +: 8] = b_buf[8*(k*N + e) +: 8];
            end
        end
    end

    // Edge registers; loading zero whenever wave_en is low keeps the lines quiet outside FEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            arr_a <= '0;
            arr_b <= '0;
        end else begin
            arr_a <= a_wave;
            arr_b <= b_wave;
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary FP8 systolic array: holds the
// A/B tiles, clears the accumulators, feeds skewed wavefronts, captures the
// BF16 results and streams them out over valid/ready.
// Optional macro SYSTOLIC_SEQ_PERF_EN adds a saturating busy-cycle counter.
//
// state   | meaning
// IDLE    | waiting for start; operand buffer writes accepted
// CLEAR   | one cycle of arr_clear, feed lines zero
// FEED    | t = 0..K+2N-3, skewed operands on the array edges
// CAPTURE | feed lines zero, all arr_c values latched
// OUT     | result beats 0..N*N-1 on the valid/ready port
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int K  = K_DEFAULT,
    parameter int AW = $clog2(N*K)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [AW-1:0]            wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     arr_clear,
    output logic [8*N-1:0]           arr_a,
    output logic [8*N-1:0]           arr_b,
    input  logic [BF16_W*N*N-1:0]    arr_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BF16_W-1:0]        out_data,
    output logic [$clog2(N*N)-1:0]   out_idx
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]              perf_cycles
`endif
);

    localparam int FEED_LEN = K + 2*N - 2;
    localparam int TW       = $clog2(FEED_LEN + 1);
    localparam int NR       = N*N;
    localparam int IW       = $clog2(NR);

    state_e              state_q, state_d;
    logic [TW-1:0]       t_q, t_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                clear_q, clear_d;
    logic                valid_q, valid_d;
    logic [BF16_W-1:0]   data_q, data_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                capture;
    logic                wave_en;
    logic [BF16_W*NR-1:0] res_q;
    logic [8*N*K-1:0]    a_buf_q;
    logic [8*N*K-1:0]    b_buf_q;

    // Next-state and output-register logic for the tile sequence.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        clear_d = 1'b0;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    busy_d  = 1'b1;
                    clear_d = 1'b1;
                end
            end
            CLEAR: begin
                state_d = FEED;
                t_d     = '0;
            end
            FEED: begin
                if (t_q == TW'(FEED_LEN - 1)) state_d = CAPTURE;
                else                          t_d     = t_q + 1'b1;
            end
            CAPTURE: begin
                state_d = OUT;
                capture = 1'b1;
                valid_d = 1'b1;
                idx_d   = '0;
                data_d  = arr_c[BF16_W-1:0];
            end
            OUT: begin
                if (out_ready) begin
                    if (idx_q == IW'(NR - 1)) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        data_d  = '0;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        data_d = res_q[BF16_W*(int'(idx_q) + 1) +: BF16_W];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The edge registers load the wave for the step the FSM is entering.
    assign wave_en = (state_d == FEED);

    systolic_skew_gen #(.N(N), .K(K), .TW(TW)) u_skew (
        .clk     (clk),
        .rst     (rst),
        .wave_en (wave_en),
        .t       (t_d),
        .a_buf   (a_buf_q),
        .b_buf   (b_buf_q),
        .arr_a   (arr_a),
        .arr_b   (arr_b)
    );

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clear_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clear_q <= clear_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    // Result snapshot; only meaningful after a CAPTURE, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) res_q <= arr_c;
    end

    // Operand buffers are writable only while idle; addresses past N*K are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == IDLE && int'(wr_addr) < N*K) begin
            if (wr_sel == SEL_A)      a_buf_q[8*int'(wr_addr) +: 8] <= wr_data;
            else if (wr_sel == SEL_B) b_buf_q[8*int'(wr_addr) +: 8] <= wr_data;
        end
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter; survives start and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst)                          perf_q <= '0;
        else if (busy_q && perf_q != '1)  perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign arr_clear = clear_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of FP8 (E4M3) MAC PEs with BF16 results.
- Holds the A (N x K) and B (K x N) operand tiles in internal byte buffers and drives the skewed operand wavefronts into the array edges.
- Asserts the array accumulator clear, then latches the N*N BF16 results and streams them out over a valid/ready port.
- Sits between the host/load bus and the PE grid; it is the only block that drives the array's edge inputs and clear.

Parameters:
- N, 4, array dimension (rows = cols); valid range 2..8.
- K, 4, reduction depth (beats per dot product); valid range 1..16.
- AW, $clog2(N*K), operand buffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  operand buffer write strobe.
- wr_sel  in  1  0 = A buffer, 1 = B buffer.
- wr_addr  in  AW  A: i*K+k; B: k*N+j.
- wr_data  in  8  FP8 E4M3 operand byte.
- start  in  1  begin a tile computation.
- busy  out  1  high from the cycle after start is accepted until the last result beat completes.
- done  out  1  one-cycle pulse in the cycle after the final out beat.
- arr_clear  out  1  to the clear input of every PE.
- arr_a  out  8*N  row-edge operands; byte i feeds row i.
- arr_b  out  8*N  column-edge operands; byte j feeds column j.
- arr_c  in  16*N*N  PE c_out values, index i*N+j.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer ready.
- out_data  out  16  BF16 result.
- out_idx  out  $clog2(N*N)  result index, i*N+j.

Behaviour:
- Reset: state IDLE; busy, done, arr_clear, out_valid = 0; arr_a, arr_b, out_data, out_idx = 0; counters 0. Buffer contents are not reset.
- Reset mid-operation: return to IDLE on the next edge. Results in flight are discarded; no done pulse.
- Writes: accepted only in IDLE. wr_en while busy is ignored. Out-of-range addresses are ignored.
- FSM states:
  - IDLE -> CLEAR when start=1. start while busy is ignored.
  - CLEAR (1 cycle): arr_clear=1, arr_a/arr_b=0.
  - FEED (K+2N-2 cycles, counter t=0..K+2N-3):
    - arr_a byte i = A[i][t-i] when 0 <= t-i < K, else 0x00.
    - arr_b byte j = B[t-j][j] when 0 <= t-j < K, else 0x00.
    - arr_clear=0. Outputs are registered, so each value is valid in the cycle it is presented.
  - CAPTURE (1 cycle): arr_a/arr_b=0x00, so accumulators hold (0x00 contributes zero). All N*N arr_c values are latched into the result buffer.
  - OUT: beats in index order 0..N*N-1.
    - out_valid=1; out_data and out_idx stay stable until out_ready is sampled high.
    - After the last accepted beat -> IDLE with done=1 for one cycle.
- Feed lines are held at 0x00 in every state except FEED.
- Latency: start sampled at edge 0 gives CLEAR in cycle 1, FEED in cycles 2..K+2N-1, CAPTURE in cycle K+2N, first out_valid in cycle K+2N+1. With N=4, K=4: first out_valid at cycle 13. Minimum total time to done = K+2N+1+N*N cycles.
- out_ready may be held high permanently; then one beat is transferred per cycle.
- start in the same cycle as the done pulse is accepted (the FSM is already in IDLE).

Optional Feature:
- SYSTOLIC_SEQ_PERF_EN
- With the macro: adds output perf_cycles [31:0]. It counts every cycle with busy=1, including backpressure stalls, is cleared on rst, is never cleared by start, and saturates at all-ones.
- Without the macro: the port and counter are absent; nothing else changes.

Decomposition:
- Package systolic_pkg holds:
  - FSM state enum (IDLE, CLEAR, FEED, CAPTURE, OUT).
  - Default N and K.
  - FP8_ZERO = 8'h00.
  - BF16_W = 16.
  - Operand select constants SEL_A = 0, SEL_B = 1.
- One sub-module, systolic_skew_gen: combinational wavefront index and valid generation from t, plus registered arr_a/arr_b. It is instantiated once and serves both edges.

Test Plan:
- Ones tile: N=4, K=4, all A and B = 0x38 (1.0), start -> 16 beats, each out_data=0x4080 (4.0); out_idx 0..15 in order; done pulses once.
- Latency and skew: same stimulus; monitor arr_a/arr_b -> arr_clear high only in cycle 1; byte i first nonzero at cycle 2+i; first out_valid at cycle 13.
- Sign: A[0][0]=0xB8 (-1.0), all other A = 0x00, all B = 0x38 -> row 0 results 0xBF80; all other results 0x0000.
- Backpressure: out_ready toggled 1,0,0,1,... -> out_data and out_idx stable while stalled; no beat lost or duplicated; done only after idx 15 is accepted.
- Protocol abuse: start and wr_en pulsed during FEED -> ignored; buffer contents and results unchanged.
- Reset mid-FEED: rst for one cycle at t=3 -> next cycle IDLE, busy=0, no done pulse. A fresh start then yields correct 0x4080 results.
